// File: rtl/tmvp_ram_pkg.sv
// Shared types and constants for the TMVP coefficient RAM access blocks.
package tmvp_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DONE
    } rd_state_e;

    localparam int unsigned READ_LATENCY   = 1;
    localparam int unsigned OUT_FIFO_DEPTH = 2;

endpackage

// File: rtl/tmvp_skid_fifo2.sv
// Two-entry valid/ready FIFO; push and pop may occur in the same cycle.
module tmvp_skid_fifo2 #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             rd_q;
    logic             wr_q;
    logic [1:0]       cnt_q;
    logic             pop_ok;

    assign valid_o = (cnt_q != 2'd0);
    assign pop_ok  = pop_i & valid_o;
    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= ~wr_q;
            end
            if (pop_ok) begin
                rd_q <= ~rd_q;
            end
            cnt_q <= cnt_q + 2'(push_i) - 2'(pop_ok);
        end
    end

endmodule

// File: rtl/tmvp_ram_burst_reader.sv
// Burst reader for the coefficient RAM: issues credit-limited reads and
// streams the returned words with a last flag on the final beat.
module tmvp_ram_burst_reader
    import tmvp_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_data,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    rd_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic                  pend_q;
    logic                  pend_last_q;

    logic [DATA_WIDTH:0]   head;
    logic [1:0]            fifo_cnt;
    logic                  pop;
    logic                  credit_ok;
    logic                  issue;

    assign pop = out_valid & out_ready;

    // Buffered plus in-flight words, minus this cycle's pop, must stay below depth.
    assign credit_ok = ({1'b0, fifo_cnt} + 3'(pend_q)) < (3'(OUT_FIFO_DEPTH) + 3'(pop));
    assign issue     = (state_q == ST_READ) && (rem_q != '0) && credit_ok;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    rem_d   = length;
                    state_d = (length != '0) ? ST_READ : ST_DONE;
                end
            end
            ST_READ: begin
                if (issue) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    rem_d  = rem_q - LEN_WIDTH'(1);
                end
                if (pop && head[DATA_WIDTH]) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            pend_q      <= issue;
            pend_last_q <= issue && (rem_q == LEN_WIDTH'(1));
        end
    end

    tmvp_skid_fifo2 #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_out_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (pend_q),
        .push_data_i({pend_last_q, ram_q}),
        .pop_i      (pop),
        .head_o     (head),
        .valid_o    (out_valid),
        .count_o    (fifo_cnt)
    );

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign ram_addr = addr_q;
    assign ram_we   = 1'b0;
    assign ram_data = '0;
    assign out_data = head[DATA_WIDTH-1:0];
    assign out_last = out_valid & head[DATA_WIDTH];

endmodule

// File: tb/tb_tmvp_ram_burst_reader.sv
// Randomised bench for tmvp_ram_burst_reader against a queue-based burst model.
module tb_tmvp_ram_burst_reader;

    localparam int DW = 8;
    localparam int AW = 6;
    localparam int LW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] length;
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] ram_q;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    logic [DW-1:0] mem [64];

    int n_cmp = 0;
    int n_bad = 0;

    tmvp_ram_burst_reader #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .LEN_WIDTH (LW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_addr(base_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_data (ram_data),
        .ram_q    (ram_q),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    // Read-first RAM port with one cycle of registered latency.
    always @(posedge clk) ram_q <= mem[ram_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: ready always 1; mode 1: ready pattern 1,0,0,1; mode 2: random ready.
    task automatic run_burst(input logic [AW-1:0] b, input int len, input int mode, input bit inject);
        logic [DW:0]   expq[$];
        logic [DW:0]   prev_beat;
        logic [AW-1:0] ahead;
        bit            prev_stall;
        bit            r;
        int            acc;
        int            cyc;
        int            first_valid;
        int            done_cyc;
        prev_beat   = '0;
        prev_stall  = 1'b0;
        acc         = 0;
        first_valid = -1;
        done_cyc    = -1;
        for (int k = 0; k < len; k++)
            expq.push_back({(k == len - 1), mem[(int'(b) + k) % 64]});

        @(negedge clk);
        start     = 1'b1;
        base_addr = b;
        length    = LW'(len);
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (cyc < 400) begin
            check("busy_in_burst", busy, 1);
            ahead = ram_addr - b - AW'(acc);
            check("addr_ahead_le2", (ahead <= 2), 1);
            if (len == 0) check("addr_len0", ram_addr, b);
            if (prev_stall) check("stall_hold", {out_last, out_data}, prev_beat);
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (done) begin
                done_cyc = cyc;
                check("beats_remaining", expq.size(), 0);
                break;
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready = r;
            if (out_valid) begin
                if (expq.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else if (r) begin
                    check("beat", {out_last, out_data}, expq.pop_front());
                    acc++;
                end
            end
            prev_stall = out_valid & ~r;
            prev_beat  = {out_last, out_data};
            if (inject && cyc == 4) begin
                start     = 1'b1;
                base_addr = AW'(20);
                length    = LW'(3);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (done_cyc < 0) check("done_timeout", 0, 1);
        if (len == 0) begin
            check("len0_no_valid", first_valid, -1);
            check("len0_done_early", (done_cyc >= 1 && done_cyc <= 2), 1);
        end else if (mode == 0) begin
            check("first_valid_cycle", first_valid, 3);
            check("done_cycle", done_cyc, len + 3);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_valid", out_valid, 0);
    endtask

    initial begin
        int acc;
        for (int i = 0; i < 64; i++) mem[i] = DW'(i);
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        out_ready = 1'b1;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_we", ram_we, 0);
        check("rst_wdata", ram_data, 0);
        @(negedge clk);
        rst = 1'b0;

        run_burst(AW'(4), 5, 0, 1'b0);
        run_burst(AW'(62), 4, 0, 1'b0);
        run_burst(AW'(7), 8, 1, 1'b0);
        run_burst(AW'(50), 0, 0, 1'b0);

        // Reset after three accepted beats of a ten-beat burst.
        @(negedge clk);
        start     = 1'b1;
        base_addr = AW'(10);
        length    = LW'(10);
        @(negedge clk);
        start = 1'b0;
        acc   = 0;
        for (int c = 0; c < 50 && acc < 3; c++) begin
            if (out_valid) acc++;
            if (acc < 3) @(negedge clk);
        end
        check("pre_rst_beats", acc, 3);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_last", out_last, 0);
        check("midrst_data", out_data, 0);
        check("midrst_addr", ram_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        run_burst(AW'(0), 2, 0, 1'b0);

        run_burst(AW'(30), 10, 0, 1'b1);
        run_burst(AW'(0), 64, 1, 1'b0);

        for (int t = 0; t < 8; t++) begin
            mem[$urandom_range(0, 63)] = DW'($urandom);
            run_burst(AW'($urandom_range(0, 63)), int'($urandom_range(0, 64)), 2, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
